// File: rtl/instr_word_encoder_pkg.sv
// mips_isa_pkg: opcode constants, request classes and word encoder shared with the control decoder.
package mips_isa_pkg;
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_LW   = 3'd1;
  localparam logic [2:0] CLS_SW   = 3'd2;
  localparam logic [2:0] CLS_BEQ  = 3'd3;
  localparam logic [2:0] CLS_ADDI = 3'd4;
  localparam logic [2:0] CLS_SLTI = 3'd5;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;
  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
  } req_t;
  function automatic logic is_legal(logic [2:0] cls);
    return cls <= CLS_SLTI;
  endfunction
  function automatic logic [31:0] encode(req_t r);
    logic [5:0] op;
    op = r.cls == CLS_LW   ? LW   :
         r.cls == CLS_SW   ? SW   :
         r.cls == CLS_BEQ  ? BEQ  :
         r.cls == CLS_ADDI ? ADDI : SLTI;
    return r.cls == CLS_R ? {R_TYPE, r.rs, r.rt, r.rd, 5'd0, r.funct} : {op, r.rs, r.rt, r.imm};
  endfunction
endpackage

// File: rtl/instr_word_encoder_if.sv
// instr_word_encoder_if: request bus, memory write port and status of the instruction word encoder.
interface instr_word_encoder_if #(parameter int ADDR_W = 32);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_class_i;
  logic [4:0]        req_rs_i;
  logic [4:0]        req_rt_i;
  logic [4:0]        req_rd_i;
  logic [5:0]        req_funct_i;
  logic [15:0]       req_imm_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              mem_ready_i;
  logic              err_o;
  logic              done_o;
  logic [ADDR_W-1:0] count_o;
  modport master (
    output req_valid_i, req_class_i, req_rs_i, req_rt_i, req_rd_i, req_funct_i, req_imm_i, mem_ready_i,
    input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o, err_o, done_o, count_o
  );
  modport slave (
    input  req_valid_i, req_class_i, req_rs_i, req_rt_i, req_rd_i, req_funct_i, req_imm_i, mem_ready_i,
    output req_ready_o, mem_we_o, mem_addr_o, mem_data_o, err_o, done_o, count_o
  );
endinterface

// File: rtl/instr_word_encoder_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy output; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = occ == OW'(DEPTH);
  assign empty   = occ == '0;
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      occ <= occ + OW'(do_push) - OW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_word_encoder.sv
// instr_word_encoder: encodes MIPS instruction requests into a FIFO and writes them to sequential memory words.
module instr_word_encoder
  import mips_isa_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                MEM_WORDS  = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  instr_word_encoder_if.slave bus
);
  localparam int                OW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS);
  state_e            state, state_n;
  req_t              req;
  logic [31:0]       word;
  logic [OW-1:0]     occ;
  logic              full, empty, accept, push, pop, err_q;
  logic [ADDR_W-1:0] addr, count, reserved;
  assign req = '{cls: bus.req_class_i, rs: bus.req_rs_i, rt: bus.req_rt_i, rd: bus.req_rd_i,
                 funct: bus.req_funct_i, imm: bus.req_imm_i};
  assign word = encode(req);
  // Buffered words count against capacity so nothing is accepted that could not be written.
  assign reserved        = count + ADDR_W'(occ);
  assign bus.req_ready_o = !full && reserved < LIMIT && state != DONE;
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign push            = accept && is_legal(req.cls);
  assign pop             = !empty && bus.mem_ready_i;
  assign bus.mem_we_o    = !empty;
  assign bus.mem_addr_o  = addr;
  assign bus.count_o     = count;
  assign bus.err_o       = err_q;
  assign bus.done_o      = state == DONE;
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .dout  (bus.mem_data_o),
    .full  (full),
    .empty (empty),
    .occ   (occ)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      addr  <= BASE_ADDR;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= accept && !is_legal(req.cls);
      if (pop) begin
        addr  <= addr + ADDR_W'(4);
        count <= count + ADDR_W'(1);
      end
    end
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE && push                                 ? ACTIVE :
              state == ACTIVE && pop && count + ADDR_W'(1) == LIMIT ? DONE   :
              state == ACTIVE && pop && !push && occ == OW'(1)      ? IDLE   : state;
  end
endmodule

// File: tb/tb_instr_word_encoder.sv
// tb_instr_word_encoder: scoreboard bench for the instruction word encoder (default and 3-word capacity).
module tb_instr_word_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_addr0 = 0, exp_addr1 = 0;
  int wr0 = 0, wr1 = 0;

  always #5 clk = ~clk;

  instr_word_encoder_if #(.ADDR_W(32)) if0 ();
  instr_word_encoder_if #(.ADDR_W(32)) if1 ();

  instr_word_encoder d0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  instr_word_encoder #(.MEM_WORDS(3)) d1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  function automatic logic [31:0] enc(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm);
    logic [5:0] op;
    op = c == 3'd1 ? 6'h23 : c == 3'd2 ? 6'h2B : c == 3'd3 ? 6'h04 : c == 3'd4 ? 6'h08 : 6'h0A;
    return c == 3'd0 ? {6'h00, rs, rt, rd, 5'd0, f} : {op, rs, rt, imm};
  endfunction

  always @(negedge clk) begin
    if (rst) exp_addr0 = 0;
    else if (if0.mem_we_o && if0.mem_ready_i) begin
      logic [31:0] w;
      w = q0.size() != 0 ? q0.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (if0.mem_data_o !== w) begin
        failures++;
        $display("FAIL d0_write_data got=%h want=%h", if0.mem_data_o, w);
      end
      checks++;
      if (if0.mem_addr_o !== exp_addr0) begin
        failures++;
        $display("FAIL d0_write_addr got=%h want=%h", if0.mem_addr_o, exp_addr0);
      end
      exp_addr0 += 4;
      wr0++;
    end
  end

  always @(negedge clk) begin
    if (rst) exp_addr1 = 0;
    else if (if1.mem_we_o && if1.mem_ready_i) begin
      logic [31:0] w;
      w = q1.size() != 0 ? q1.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (if1.mem_data_o !== w) begin
        failures++;
        $display("FAIL d1_write_data got=%h want=%h", if1.mem_data_o, w);
      end
      checks++;
      if (if1.mem_addr_o !== exp_addr1) begin
        failures++;
        $display("FAIL d1_write_addr got=%h want=%h", if1.mem_addr_o, exp_addr1);
      end
      exp_addr1 += 4;
      wr1++;
    end
  end

  task automatic idle_inputs();
    if0.req_valid_i = 0; if0.req_class_i = 0; if0.req_rs_i = 0; if0.req_rt_i = 0;
    if0.req_rd_i = 0; if0.req_funct_i = 0; if0.req_imm_i = 0; if0.mem_ready_i = 0;
    if1.req_valid_i = 0; if1.req_class_i = 0; if1.req_rs_i = 0; if1.req_rt_i = 0;
    if1.req_rd_i = 0; if1.req_funct_i = 0; if1.req_imm_i = 0; if1.mem_ready_i = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q0.delete();
    q1.delete();
  endtask

  task automatic send(input bit sel, input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm);
    bit ok = 0;
    if (sel) begin
      if1.req_valid_i = 1; if1.req_class_i = c; if1.req_rs_i = rs; if1.req_rt_i = rt;
      if1.req_rd_i = rd; if1.req_funct_i = f; if1.req_imm_i = imm;
    end else begin
      if0.req_valid_i = 1; if0.req_class_i = c; if0.req_rs_i = rs; if0.req_rt_i = rt;
      if0.req_rd_i = rd; if0.req_funct_i = f; if0.req_imm_i = imm;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? if1.req_ready_o : if0.req_ready_o;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=ready_low want=ready_high");
    end else if (c <= 3'd5) begin
      if (sel) q1.push_back(enc(c, rs, rt, rd, f, imm));
      else q0.push_back(enc(c, rs, rt, rd, f, imm));
    end
    @(posedge clk);
    #1;
    if0.req_valid_i = 0;
    if1.req_valid_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({if0.mem_we_o, if0.err_o, if0.done_o, if0.req_ready_o} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0001", {if0.mem_we_o, if0.err_o, if0.done_o, if0.req_ready_o});
    end
    checks++;
    if (if0.mem_addr_o !== 32'h0 || if0.count_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr_count got=%h/%h want=0/0", if0.mem_addr_o, if0.count_o);
    end
    checks++;
    if (if1.req_ready_o !== 1'b1 || if1.done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_d1 got=%b%b want=10", if1.req_ready_o, if1.done_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype();
    do_reset();
    if0.mem_ready_i = 1;
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0);
    @(negedge clk);
    checks++;
    if (if0.mem_we_o !== 1'b1 || if0.mem_data_o !== 32'h0022_1820 || if0.mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL rtype_word got=we%b %h@%h want=we1 00221820@0", if0.mem_we_o, if0.mem_data_o, if0.mem_addr_o);
    end
    @(negedge clk);
    checks++;
    if (if0.count_o !== 32'd1 || if0.mem_we_o !== 1'b0) begin
      failures++;
      $display("FAIL rtype_count got=%0d we%b want=1 we0", if0.count_o, if0.mem_we_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if0.mem_ready_i = 1;
    checks++;
    if (enc(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004) !== 32'h8C08_0004) begin
      failures++;
      $display("FAIL lw_model got=%h want=8c080004", enc(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004));
    end
    send(0, 3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004);
    send(0, 3'd4, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF);
    for (int i = 0; i < 100 && (q0.size() != 0 || if0.mem_we_o); i++) @(negedge clk);
    checks++;
    if (if0.count_o !== 32'd2 || if0.mem_addr_o !== 32'd8 || q0.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d addr=%h left=%0d want=2 8 0", if0.count_o, if0.mem_addr_o, q0.size());
    end
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    base = wr0;
    for (int i = 0; i < 4; i++) send(0, 3'd2, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(i * 8));
    if0.req_valid_i = 1; if0.req_class_i = 3'd3; if0.req_rs_i = 5'd7; if0.req_imm_i = 16'h1234;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (if0.req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL full_ready got=%b want=0", if0.req_ready_o);
      end
    end
    checks++;
    if (if0.mem_data_o !== enc(3'd2, 5'd0, 5'd1, 5'd0, 6'd0, 16'd0) || if0.mem_addr_o !== 32'h0 || if0.mem_we_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold got=%h@%h we%b want=%h@0 we1", if0.mem_data_o, if0.mem_addr_o, if0.mem_we_o,
               enc(3'd2, 5'd0, 5'd1, 5'd0, 6'd0, 16'd0));
    end
    @(posedge clk);
    #1;
    if0.req_valid_i = 0;
    if0.mem_ready_i = 1;
    for (int i = 0; i < 100 && (q0.size() != 0 || if0.mem_we_o); i++) @(negedge clk);
    checks++;
    if (wr0 - base != 4 || if0.count_o !== 32'd4 || if0.mem_addr_o !== 32'd16) begin
      failures++;
      $display("FAIL drain4 got=wr%0d cnt%0d addr%h want=wr4 cnt4 addr10", wr0 - base, if0.count_o, if0.mem_addr_o);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    if0.mem_ready_i = 1;
    send(0, 3'd7, 5'd1, 5'd2, 5'd3, 6'h20, 16'h5555);
    @(negedge clk);
    checks++;
    if (if0.err_o !== 1'b1 || if0.mem_we_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_err got=err%b we%b want=err1 we0", if0.err_o, if0.mem_we_o);
    end
    @(negedge clk);
    checks++;
    if (if0.err_o !== 1'b0 || if0.count_o !== 32'd0) begin
      failures++;
      $display("FAIL illegal_pulse got=err%b cnt%0d want=err0 cnt0", if0.err_o, if0.count_o);
    end
    @(posedge clk);
    #1;
    send(0, 3'd5, 5'd3, 5'd4, 5'd0, 6'd0, 16'h8000);
    for (int i = 0; i < 100 && (q0.size() != 0 || if0.mem_we_o); i++) @(negedge clk);
    checks++;
    if (if0.count_o !== 32'd1 || if0.err_o !== 1'b0) begin
      failures++;
      $display("FAIL after_illegal got=cnt%0d err%b want=cnt1 err0", if0.count_o, if0.err_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if0.mem_ready_i = (i % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      send(0, 3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
    end
    if0.mem_ready_i = 1;
    for (int i = 0; i < 100 && (q0.size() != 0 || if0.mem_we_o); i++) @(negedge clk);
    checks++;
    if (if0.count_o !== 32'd10 || if0.mem_addr_o !== 32'd40) begin
      failures++;
      $display("FAIL random_count got=cnt%0d addr%h want=cnt10 addr28", if0.count_o, if0.mem_addr_o);
    end
  endtask

  task automatic test_capacity();
    int base;
    do_reset();
    base = wr1;
    for (int i = 0; i < 3; i++) send(1, 3'd4, 5'(i), 5'(i + 10), 5'd0, 6'd0, 16'(100 + i));
    if1.req_valid_i = 1; if1.req_class_i = 3'd1; if1.req_imm_i = 16'h0BAD;
    @(negedge clk);
    checks++;
    if (if1.req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL cap_ready got=%b want=0", if1.req_ready_o);
    end
    @(posedge clk);
    #1 if1.mem_ready_i = 1;
    for (int i = 0; i < 50 && !if1.done_o; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (if1.done_o !== 1'b1 || if1.mem_we_o !== 1'b0 || if1.req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL cap_done got=done%b we%b rdy%b want=done1 we0 rdy0", if1.done_o, if1.mem_we_o, if1.req_ready_o);
    end
    checks++;
    if (wr1 - base != 3 || if1.count_o !== 32'd3 || if1.mem_addr_o !== 32'd12) begin
      failures++;
      $display("FAIL cap_count got=wr%0d cnt%0d addr%h want=wr3 cnt3 addrc", wr1 - base, if1.count_o, if1.mem_addr_o);
    end
    if1.req_valid_i = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) send(0, 3'd3, 5'(i), 5'(i), 5'd0, 6'd0, 16'hFFF0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q0.delete();
    @(negedge clk);
    checks++;
    if (if0.mem_we_o !== 1'b0 || if0.mem_addr_o !== 32'h0 || if0.count_o !== 32'h0 || if0.done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=we%b addr%h cnt%0d done%b want=we0 addr0 cnt0 done0",
               if0.mem_we_o, if0.mem_addr_o, if0.count_o, if0.done_o);
    end
    checks++;
    if (if0.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready got=%b want=1", if0.req_ready_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_rtype();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    test_capacity();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
